// File: rtl/pipeline_sequencer_pkg.sv
// Shared types and control-word constants for the pipeline sequencer.
// Each stage-control word carries the PC enable plus per-stage enables and flushes.
package pipeline_sequencer_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DWAIT  = 2'd1,
    DDONE  = 2'd2,
    HALTED = 2'd3
  } pipe_seq_state_t;

  // Vector bit positions for the four pipeline registers
  localparam int unsigned STG_IF_ID  = 3;
  localparam int unsigned STG_ID_EX  = 2;
  localparam int unsigned STG_EX_MEM = 1;
  localparam int unsigned STG_MEM_WB = 0;

  typedef struct packed {
    logic       pc_en;
    logic [3:0] en;
    logic [3:0] fl;
  } stage_ctl_t;

  localparam stage_ctl_t CTL_FROZEN   = '{pc_en: 1'b0, en: 4'b0000, fl: 4'b0000};
  localparam stage_ctl_t CTL_RESET    = '{pc_en: 1'b0, en: 4'b0000, fl: 4'b1111};
  localparam stage_ctl_t CTL_ADVANCE  = '{pc_en: 1'b1, en: 4'b1111, fl: 4'b0000};
  // Load-use bubble: hold PC and IF/ID, squash ID/EX, let the back end drain
  localparam stage_ctl_t CTL_LOAD_USE = '{pc_en: 1'b0, en: 4'b0111, fl: 4'b0100};
  localparam stage_ctl_t CTL_REDIRECT = '{pc_en: 1'b1, en: 4'b1111, fl: 4'b1100};
  localparam stage_ctl_t CTL_HALT     = '{pc_en: 1'b0, en: 4'b1111, fl: 4'b1110};

endpackage

// File: rtl/pipeline_sequencer_if.sv
// Bundle between the pipeline sequencer (master) and the datapath/memory side (slave).
interface pipeline_sequencer_if #(
  parameter int CNT_W = 32
) ();

  logic             ihit;
  logic             dhit;
  logic             dREN_EX_MEM;
  logic             dWEN_EX_MEM;
  logic             halt_EX_MEM;
  logic             dREN_ID_EX;
  logic [4:0]       Rt_ID_EX;
  logic [4:0]       Rs_IF_ID;
  logic [4:0]       Rt_IF_ID;
  logic             redirect_EX;

  logic             pc_en;
  logic             enable_IF_ID;
  logic             enable_ID_EX;
  logic             enable_EX_MEM;
  logic             enable_MEM_WB;
  logic             flush_IF_ID;
  logic             flush_ID_EX;
  logic             flush_EX_MEM;
  logic             flush_MEM_WB;
  logic             imemREN;
  logic             dmemREN;
  logic             dmemWEN;
  logic             halt;
  logic [CNT_W-1:0] stall_count;
  logic [CNT_W-1:0] squash_count;

  modport master (
    input  ihit, dhit, dREN_EX_MEM, dWEN_EX_MEM, halt_EX_MEM,
           dREN_ID_EX, Rt_ID_EX, Rs_IF_ID, Rt_IF_ID, redirect_EX,
    output pc_en, enable_IF_ID, enable_ID_EX, enable_EX_MEM, enable_MEM_WB,
           flush_IF_ID, flush_ID_EX, flush_EX_MEM, flush_MEM_WB,
           imemREN, dmemREN, dmemWEN, halt, stall_count, squash_count
  );

  modport slave (
    output ihit, dhit, dREN_EX_MEM, dWEN_EX_MEM, halt_EX_MEM,
           dREN_ID_EX, Rt_ID_EX, Rs_IF_ID, Rt_IF_ID, redirect_EX,
    input  pc_en, enable_IF_ID, enable_ID_EX, enable_EX_MEM, enable_MEM_WB,
           flush_IF_ID, flush_ID_EX, flush_EX_MEM, flush_MEM_WB,
           imemREN, dmemREN, dmemWEN, halt, stall_count, squash_count
  );

endinterface

// File: rtl/pipeline_sequencer_hazard_detect.sv
// Load-use detector: a load in EX whose destination feeds the instruction in ID.
// Register $0 is never a real dependency.
module pipeline_sequencer_hazard_detect
  import pipeline_sequencer_pkg::*;
#(
  parameter bit LOAD_USE_EN = 1'b1
) (
  input  logic       dren_ex_i,
  input  logic [4:0] rt_ex_i,
  input  logic [4:0] rs_id_i,
  input  logic [4:0] rt_id_i,
  output logic       hazard_o
);

  logic dst_live;
  logic src_match;

  assign dst_live  = (rt_ex_i != 5'd0);
  assign src_match = (rt_ex_i == rs_id_i) || (rt_ex_i == rt_id_i);
  assign hazard_o  = LOAD_USE_EN && dren_ex_i && dst_live && src_match;

endmodule

// File: rtl/pipeline_sequencer.sv
// Central sequencer for the 5-stage pipeline: stage enables/flushes, memory request
// gating, halt freeze and saturating stall/squash counters.
module pipeline_sequencer
  import pipeline_sequencer_pkg::*;
#(
  parameter int CNT_W       = 32,
  parameter bit LOAD_USE_EN = 1'b1
) (
  input  logic                 CLK,
  input  logic                 RST,
  pipeline_sequencer_if.master bus
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  pipe_seq_state_t  state_q;
  logic             halt_q;
  logic [CNT_W-1:0] stall_q;
  logic [CNT_W-1:0] squash_q;

  logic       dreq;
  logic       dsat;
  logic       advance;
  logic       load_use;
  logic       gate_open;
  stage_ctl_t ctl;
  logic       dmem_ren;
  logic       dmem_wen;

  assign dreq      = bus.dREN_EX_MEM | bus.dWEN_EX_MEM;
  assign dsat      = bus.dhit | (state_q == DDONE);
  assign advance   = bus.ihit & (~dreq | dsat) & (state_q != HALTED) & ~RST;
  // A data access already satisfied in DDONE must not be re-issued to memory
  assign gate_open = (state_q != DDONE) && (state_q != HALTED);

  pipeline_sequencer_hazard_detect #(
    .LOAD_USE_EN (LOAD_USE_EN)
  ) u_hazard (
    .dren_ex_i (bus.dREN_ID_EX),
    .rt_ex_i   (bus.Rt_ID_EX),
    .rs_id_i   (bus.Rs_IF_ID),
    .rt_id_i   (bus.Rt_IF_ID),
    .hazard_o  (load_use)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= RUN;
      halt_q   <= 1'b0;
      stall_q  <= '0;
      squash_q <= '0;
    end else begin
      if (advance && bus.halt_EX_MEM) begin
        state_q <= HALTED;
        halt_q  <= 1'b1;
      end else begin
        case (state_q)
          RUN: begin
            if (dreq && !bus.dhit) begin
              state_q <= DWAIT;
            end else if (dreq && bus.dhit && !bus.ihit) begin
              state_q <= DDONE;
            end else begin
              state_q <= RUN;
            end
          end
          DWAIT: begin
            if (bus.dhit && bus.ihit) begin
              state_q <= RUN;
            end else if (bus.dhit) begin
              state_q <= DDONE;
            end else begin
              state_q <= DWAIT;
            end
          end
          DDONE: begin
            if (bus.ihit) begin
              state_q <= RUN;
            end else begin
              state_q <= DDONE;
            end
          end
          HALTED:  state_q <= HALTED;
          default: state_q <= RUN;
        endcase
      end
      if (!advance && (state_q != HALTED) && (stall_q != CNT_MAX)) begin
        stall_q <= stall_q + CNT_ONE;
      end
      if (advance && bus.redirect_EX && (squash_q != CNT_MAX)) begin
        squash_q <= squash_q + CNT_ONE;
      end
    end
  end

  // Priority on advance: halt over redirect over load-use bubble
  always_comb begin
    ctl      = CTL_FROZEN;
    dmem_ren = 1'b0;
    dmem_wen = 1'b0;
    if (RST) begin
      ctl = CTL_RESET;
    end else if (advance) begin
      if (bus.halt_EX_MEM) begin
        ctl = CTL_HALT;
      end else if (bus.redirect_EX) begin
        ctl = CTL_REDIRECT;
      end else if (load_use) begin
        ctl = CTL_LOAD_USE;
      end else begin
        ctl = CTL_ADVANCE;
      end
    end else begin
      ctl = CTL_FROZEN;
    end
    if (!RST && gate_open) begin
      dmem_ren = bus.dREN_EX_MEM;
      dmem_wen = bus.dWEN_EX_MEM;
    end else begin
      dmem_ren = 1'b0;
      dmem_wen = 1'b0;
    end
  end

  assign bus.pc_en         = ctl.pc_en;
  assign bus.enable_IF_ID  = ctl.en[STG_IF_ID];
  assign bus.enable_ID_EX  = ctl.en[STG_ID_EX];
  assign bus.enable_EX_MEM = ctl.en[STG_EX_MEM];
  assign bus.enable_MEM_WB = ctl.en[STG_MEM_WB];
  assign bus.flush_IF_ID   = ctl.fl[STG_IF_ID];
  assign bus.flush_ID_EX   = ctl.fl[STG_ID_EX];
  assign bus.flush_EX_MEM  = ctl.fl[STG_EX_MEM];
  assign bus.flush_MEM_WB  = ctl.fl[STG_MEM_WB];
  assign bus.imemREN       = (state_q != HALTED);
  assign bus.dmemREN       = dmem_ren;
  assign bus.dmemWEN       = dmem_wen;
  assign bus.halt          = halt_q;
  assign bus.stall_count   = stall_q;
  assign bus.squash_count  = squash_q;

endmodule

// File: tb/tb_pipeline_sequencer.sv
// Directed plus randomized bench for pipeline_sequencer against a flag-based reference model.
module tb_pipeline_sequencer;

  localparam int CNT_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;

  pipeline_sequencer_if #(.CNT_W(CNT_W)) bif ();

  pipeline_sequencer #(
    .CNT_W       (CNT_W),
    .LOAD_USE_EN (1'b1)
  ) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bif)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: memory-data-already-delivered flag, halted flag, counters
  bit m_halted;
  bit m_dgot;
  bit m_halt_out;
  int m_stall;
  int m_squash;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit ih, input bit dh, input bit dren, input bit dwen,
                       input bit hlt, input bit dren_id, input logic [4:0] rt_ex,
                       input logic [4:0] rs_id, input logic [4:0] rt_id, input bit redir);
    bif.ihit        = ih;
    bif.dhit        = dh;
    bif.dREN_EX_MEM = dren;
    bif.dWEN_EX_MEM = dwen;
    bif.halt_EX_MEM = hlt;
    bif.dREN_ID_EX  = dren_id;
    bif.Rt_ID_EX    = rt_ex;
    bif.Rs_IF_ID    = rs_id;
    bif.Rt_IF_ID    = rt_id;
    bif.redirect_EX = redir;
  endtask

  task automatic model_reset();
    m_halted   = 1'b0;
    m_dgot     = 1'b0;
    m_halt_out = 1'b0;
    m_stall    = 0;
    m_squash   = 0;
  endtask

  // Check one cycle against the model, clock it, then advance the model
  task automatic step(output bit adv_o);
    bit         dreq, adv, lu, pc;
    logic [3:0] en, fl;
    logic [11:0] exp_v, obs_v;
    #1;
    dreq = bif.dREN_EX_MEM || bif.dWEN_EX_MEM;
    adv  = bif.ihit && (!dreq || bif.dhit || m_dgot) && !m_halted && !rst;
    lu   = bif.dREN_ID_EX && (bif.Rt_ID_EX != 5'd0) &&
           ((bif.Rt_ID_EX == bif.Rs_IF_ID) || (bif.Rt_ID_EX == bif.Rt_IF_ID));
    if (rst) begin
      pc = 1'b0; en = 4'b0000; fl = 4'b1111;
    end else if (!adv) begin
      pc = 1'b0; en = 4'b0000; fl = 4'b0000;
    end else if (bif.halt_EX_MEM) begin
      pc = 1'b0; en = 4'b1111; fl = 4'b1110;
    end else if (bif.redirect_EX) begin
      pc = 1'b1; en = 4'b1111; fl = 4'b1100;
    end else if (lu) begin
      pc = 1'b0; en = 4'b0111; fl = 4'b0100;
    end else begin
      pc = 1'b1; en = 4'b1111; fl = 4'b0000;
    end
    exp_v = {pc, en, fl, !m_halted,
             bif.dREN_EX_MEM && !m_dgot && !m_halted && !rst,
             bif.dWEN_EX_MEM && !m_dgot && !m_halted && !rst};
    obs_v = {bif.pc_en, bif.enable_IF_ID, bif.enable_ID_EX, bif.enable_EX_MEM,
             bif.enable_MEM_WB, bif.flush_IF_ID, bif.flush_ID_EX, bif.flush_EX_MEM,
             bif.flush_MEM_WB, bif.imemREN, bif.dmemREN, bif.dmemWEN};
    chk("ctl", 32'(obs_v), 32'(exp_v));
    chk("halt", 32'(bif.halt), 32'(m_halt_out));
    chk("stall_count", 32'(bif.stall_count), 32'(m_stall));
    chk("squash_count", 32'(bif.squash_count), 32'(m_squash));
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else begin
      if (!adv && !m_halted) m_stall = (m_stall == CNT_MAX) ? CNT_MAX : m_stall + 1;
      if (adv && bif.redirect_EX) m_squash = (m_squash == CNT_MAX) ? CNT_MAX : m_squash + 1;
      if (adv) begin
        m_dgot = 1'b0;
        if (bif.halt_EX_MEM) begin
          m_halted   = 1'b1;
          m_halt_out = 1'b1;
        end
      end else if (dreq && bif.dhit) begin
        m_dgot = 1'b1;
      end
    end
    adv_o = adv;
    #1;
  endtask

  task automatic cycles(input int n);
    bit a;
    for (int i = 0; i < n; i++) step(a);
  endtask

  initial begin
    bit adv;
    bit mem_free;
    bit [1:0] mk;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    model_reset();
    cycles(1);
    rst = 1'b0;

    // Free-running: no data requests
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
    cycles(10);
    chk("idle_stall", 32'(bif.stall_count), 32'd0);

    // Load waiting on dhit for 3 cycles
    drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
    cycles(3);
    chk("dwait_stall", 32'(bif.stall_count), 32'd3);
    drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
    cycles(1);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
    cycles(1);
    drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
    cycles(1);
    chk("ddone_stall", 32'(bif.stall_count), 32'd5);

    // Load-use bubble, then $0 destination ignored, then redirect overriding load-use
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd5, 5'd5, 5'd2, 1'b0);
    cycles(1);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd0, 5'd0, 5'd0, 1'b0);
    cycles(1);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd7, 5'd1, 5'd7, 1'b1);
    cycles(1);
    chk("squash_one", 32'(bif.squash_count), 32'd1);

    // Randomized traffic; MEM-stage request only changes after an advance or reset
    mem_free = 1'b1;
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 99) < 3);
      bif.ihit        = ($urandom_range(0, 3) != 0);
      bif.dhit        = ($urandom_range(0, 2) == 0);
      bif.halt_EX_MEM = ($urandom_range(0, 39) == 0);
      bif.dREN_ID_EX  = $urandom_range(0, 1);
      bif.Rt_ID_EX    = 5'($urandom_range(0, 7));
      bif.Rs_IF_ID    = 5'($urandom_range(0, 7));
      bif.Rt_IF_ID    = 5'($urandom_range(0, 7));
      bif.redirect_EX = ($urandom_range(0, 4) == 0);
      if (mem_free) begin
        mk = 2'($urandom_range(0, 2));
        bif.dREN_EX_MEM = (mk == 2'd1);
        bif.dWEN_EX_MEM = (mk == 2'd2);
      end
      step(adv);
      mem_free = adv || rst;
    end

    // Counter saturation under a long fetch stall
    rst = 1'b1;
    cycles(1);
    rst = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
    cycles(20);
    chk("stall_sat", 32'(bif.stall_count), 32'(CNT_MAX));

    // Halt retires, pipeline freezes, reset releases it
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
    cycles(1);
    chk("halt_set", 32'(bif.halt), 32'd1);
    drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1);
    cycles(3);
    chk("halt_stall_frozen", 32'(bif.stall_count), 32'(CNT_MAX));
    rst = 1'b1;
    cycles(1);
    chk("halt_clr", 32'(bif.halt), 32'd0);
    rst = 1'b0;
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
    cycles(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
